egg_timer_control: RTL and testbench

Control FSM and 1 Hz tick generator that drives the four per-digit running registers of the egg timer (sec ones, sec tens, min ones, min tens; index 0..3). It sequences set / run / pause / alarm from debounced button pulses. It produces the per-digit load, decrement, borrow-chain "done" and start strobes those registers consume. It reads back each digit's zero flag to find borrows and expiry.

---
 rtl/egg_timer_control.sv | 135 +++++++++++++
 tb/tb_egg_timer_control.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_control.sv
// rtl/egg_timer_control.sv - egg timer control FSM, 1 Hz prescaler and per-digit strobes
// Optional build macro: ALARM_TIMEOUT_EN (alarm self-clears after ALARM_SECS ticks)
module egg_timer_control #(
  parameter int TICK_DIV   = 50000000,
  parameter int CNT_W      = 26,
  parameter int ALARM_SECS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       set_load,
  input  logic [1:0] set_sel,
  input  logic [3:0] digit_zero,
  output logic [3:0] set_en,
  output logic [3:0] dec,
  output logic [3:0] done_hi,
  output logic       starting,
  output logic       tick,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] presc;
  logic             tick_r;
  logic             alarm_r;
  logic             all_zero;
  logic             presc_wrap;
  logic             timeout;
  logic             dec_go;

  assign all_zero   = &digit_zero;
  assign presc_wrap = (presc == PRESC_MAX);

`ifdef ALARM_TIMEOUT_EN
  localparam int ACNT_W = $clog2(ALARM_SECS + 1);
  logic [ACNT_W-1:0] acnt;

  assign timeout = (cur == S_ALARM) && tick_r && (acnt == ACNT_W'(ALARM_SECS - 1));

  // Held at zero outside ALARM, so it always starts fresh on ALARM entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              acnt <= '0;
    else if (cur != S_ALARM) acnt <= '0;
    else if (tick_r)         acnt <= acnt + 1'b1;
  end
`else
  // Constant false; keeps ALARM_SECS referenced when the timeout is compiled out
  assign timeout = (ALARM_SECS < 0);
`endif

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE: begin
        if (!btn_stop) begin
          if (btn_set)                     nxt = S_SET;
          else if (btn_start && !all_zero) nxt = S_RUN;
        end
      end
      S_SET: begin
        if (btn_stop || btn_set) nxt = S_IDLE;
        else if (btn_start)      nxt = all_zero ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (btn_stop)      nxt = S_PAUSE;
        else if (all_zero) nxt = S_ALARM;
      end
      S_PAUSE: begin
        if (btn_stop || btn_set) nxt = S_IDLE;
        else if (btn_start)      nxt = S_RUN;
      end
      S_ALARM: begin
        if (btn_stop || btn_set || btn_start || timeout) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Prescaler advances in every cycle whose next state counts, including the
  // start/resume cycle, so the first tick lands TICK_DIV cycles after the press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur     <= S_IDLE;
      presc   <= '0;
      tick_r  <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      cur     <= nxt;
      alarm_r <= (nxt == S_ALARM);
      if (nxt == S_IDLE) begin
        presc  <= '0;
        tick_r <= 1'b0;
      end else if (nxt == S_RUN || nxt == S_ALARM) begin
        presc  <= presc_wrap ? '0 : presc + 1'b1;
        tick_r <= presc_wrap;
      end else begin
        tick_r <= 1'b0;
      end
    end
  end

  // Strobes are gated with reset so nothing leaks while reset is held
  assign starting = reset && (cur == S_IDLE || cur == S_SET) && (nxt == S_RUN);
  assign set_en   = (reset && cur == S_SET && set_load) ? (4'b0001 << set_sel) : 4'b0000;
  assign dec_go   = reset && (cur == S_RUN) && tick_r && !all_zero && !btn_stop;

  assign dec[0] = dec_go;
  assign dec[1] = dec[0] & digit_zero[0];
  assign dec[2] = dec[1] & digit_zero[1];
  assign dec[3] = dec[2] & digit_zero[2];

  assign done_hi[3] = dec_go;
  assign done_hi[2] = dec_go & digit_zero[3];
  assign done_hi[1] = dec_go & (&digit_zero[3:2]);
  assign done_hi[0] = dec_go & (&digit_zero[3:1]);

  assign tick  = tick_r;
  assign alarm = alarm_r;
  assign state = cur;

endmodule

// File: tb/tb_egg_timer_control.sv
// tb/tb_egg_timer_control.sv - directed self-checking bench for egg_timer_control
module tb_egg_timer_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_set, btn_start, btn_stop, set_load;
  logic [1:0] set_sel;
  logic [3:0] digit_zero;
  logic [3:0] set_en, dec, done_hi;
  logic       starting, tick, alarm;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  egg_timer_control #(.TICK_DIV(4), .CNT_W(3), .ALARM_SECS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_set    (btn_set),
    .btn_start  (btn_start),
    .btn_stop   (btn_stop),
    .set_load   (set_load),
    .set_sel    (set_sel),
    .digit_zero (digit_zero),
    .set_en     (set_en),
    .dec        (dec),
    .done_hi    (done_hi),
    .starting   (starting),
    .tick       (tick),
    .alarm      (alarm),
    .state      (state)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; btn_set = 1'b0; btn_start = 1'b1; btn_stop = 1'b0;
    set_load = 1'b0; set_sel = 2'd0; digit_zero = 4'b0000;
    #12;
    check("rst_state", 4'(state), 4'd0);
    check("rst_dec", dec, 4'b0000);
    check("rst_done_hi", done_hi, 4'b0000);
    check("rst_set_en", set_en, 4'b0000);
    check("rst_starting", 4'(starting), 4'd0);
    check("rst_tick", 4'(tick), 4'd0);
    check("rst_alarm", 4'(alarm), 4'd0);
    step;
    btn_start = 1'b0; reset = 1'b1;

    // start ignored when every digit is zero
    step;
    digit_zero = 4'b1111; btn_start = 1'b1; #2;
    check("idle_zero_nostart", 4'(starting), 4'd0);
    step;
    btn_start = 1'b0; #2;
    check("idle_zero_state", 4'(state), 4'd0);

    // start and tick cadence
    step;
    digit_zero = 4'b0000; btn_start = 1'b1; #2;
    check("start_strobe", 4'(starting), 4'd1);
    for (int c = 1; c <= 12; c++) begin
      step;
      btn_start = 1'b0; #2;
      check("run_state", 4'(state), 4'd2);
      check("run_start_low", 4'(starting), 4'd0);
      check("run_tick", 4'(tick), (c % 4 == 0) ? 4'd1 : 4'd0);
      check("run_dec", dec, (c % 4 == 0) ? 4'b0001 : 4'b0000);
    end

    // borrow chain (cycles 13..20)
    step;
    digit_zero = 4'b0011; #2;
    check("nontick_dec", dec, 4'b0000);
    step; step; step; #2;
    check("chain_dec_0011", dec, 4'b0111);
    check("chain_done_0011", done_hi, 4'b1000);
    step;
    digit_zero = 4'b1110; #2;
    check("nontick_done", done_hi, 4'b0000);
    step; step; step; #2;
    check("chain_dec_1110", dec, 4'b0001);
    check("chain_done_1110", done_hi, 4'b1111);

    // expiry to ALARM, stop acknowledges
    step;
    digit_zero = 4'b1111; #2;
    check("expire_still_run", 4'(state), 4'd2);
    check("expire_alarm_low", 4'(alarm), 4'd0);
    step; #2;
    check("alarm_state", 4'(state), 4'd4);
    check("alarm_high", 4'(alarm), 4'd1);
    btn_stop = 1'b1;
    step;
    btn_stop = 1'b0; #2;
    check("alarm_ack_state", 4'(state), 4'd0);
    check("alarm_ack_low", 4'(alarm), 4'd0);

    // SET mode loading
    btn_set = 1'b1;
    step;
    btn_set = 1'b0; set_sel = 2'd2; set_load = 1'b1; #2;
    check("set_state", 4'(state), 4'd1);
    check("set_en_sel2", set_en, 4'b0100);
    step;
    set_load = 1'b0; #2;
    check("set_en_after", set_en, 4'b0000);
    set_sel = 2'd0; set_load = 1'b1; btn_set = 1'b1; #1;
    check("set_en_sel0", set_en, 4'b0001);
    step;
    set_load = 1'b0; btn_set = 1'b0; #2;
    check("set_exit_state", 4'(state), 4'd0);
    check("set_exit_en", set_en, 4'b0000);
    btn_set = 1'b1;
    step;
    btn_set = 1'b0; btn_start = 1'b1; #2;
    check("set_zero_nostart", 4'(starting), 4'd0);
    step;
    btn_start = 1'b0; #2;
    check("set_zero_idle", 4'(state), 4'd0);

    // stop coinciding with tick, pause, resume
    digit_zero = 4'b0000; btn_start = 1'b1; #1;
    check("start2_strobe", 4'(starting), 4'd1);
    for (int k = 1; k <= 4; k++) begin
      step;
      btn_start = 1'b0;
      if (k == 4) btn_stop = 1'b1;
      #2;
      check("pre_stop_tick", 4'(tick), (k == 4) ? 4'd1 : 4'd0);
    end
    check("stop_tick_dec", dec, 4'b0000);
    check("stop_tick_done", done_hi, 4'b0000);
    for (int k = 1; k <= 10; k++) begin
      step;
      btn_stop = 1'b0; #2;
      check("pause_state", 4'(state), 4'd3);
      check("pause_tick", 4'(tick), 4'd0);
    end
    step;
    btn_start = 1'b1; #2;
    check("resume_nostart", 4'(starting), 4'd0);
    for (int k = 1; k <= 4; k++) begin
      step;
      btn_start = 1'b0; #2;
      check("resume_state", 4'(state), 4'd2);
      check("resume_tick", 4'(tick), (k == 4) ? 4'd1 : 4'd0);
      check("resume_dec", dec, (k == 4) ? 4'b0001 : 4'b0000);
    end

    // async reset in the middle of a tick cycle
    reset = 1'b0; #1;
    check("async_state", 4'(state), 4'd0);
    check("async_dec", dec, 4'b0000);
    check("async_tick", 4'(tick), 4'd0);
    check("async_done", done_hi, 4'b0000);
    btn_start = 1'b1;
    step; step; #2;
    check("held_state", 4'(state), 4'd0);
    check("held_starting", 4'(starting), 4'd0);
    check("held_tick", 4'(tick), 4'd0);
    btn_start = 1'b0;
    step;
    reset = 1'b1;

    // ALARM persistence / timeout
    step;
    digit_zero = 4'b0000; btn_start = 1'b1; #2;
    check("start3_strobe", 4'(starting), 4'd1);
    step;
    btn_start = 1'b0; digit_zero = 4'b1111; #2;
    check("start3_run", 4'(state), 4'd2);
    step; #2;
    check("alarm2_state", 4'(state), 4'd4);
    step; step; #2;
    check("alarm_tick1", 4'(tick), 4'd1);
    step; step; step; step; #2;
    check("alarm_tick2", 4'(tick), 4'd1);
    check("alarm_tick2_state", 4'(state), 4'd4);
    step; #2;
`ifdef ALARM_TIMEOUT_EN
    check("timeout_state", 4'(state), 4'd0);
    check("timeout_alarm", 4'(alarm), 4'd0);
`else
    check("alarm_persist_state", 4'(state), 4'd4);
    check("alarm_persist_high", 4'(alarm), 4'd1);
    btn_start = 1'b1;
    step;
    btn_start = 1'b0; #2;
    check("alarm_start_exit", 4'(state), 4'd0);
    check("alarm_start_low", 4'(alarm), 4'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
